// File: rtl/count_compare_capture_if.sv
// count_compare_capture_if: bus between the compare/capture unit and its host
interface count_compare_capture_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] count, cmp_wdata, cmp_val, cap_val;
  logic cap_in, cmp_wr, match_pulse, ovf_pulse, cap_pulse, pwm_out, irq;
  logic [3:0] flag_clr, irq_en, flags;
  modport master (
    output count, cap_in, cmp_wr, cmp_wdata, flag_clr, irq_en,
    input cmp_val, cap_val, match_pulse, ovf_pulse, cap_pulse, pwm_out, flags, irq
  );
  modport slave (
    input count, cap_in, cmp_wr, cmp_wdata, flag_clr, irq_en,
    output cmp_val, cap_val, match_pulse, ovf_pulse, cap_pulse, pwm_out, flags, irq
  );
endinterface

// File: rtl/count_compare_capture.sv
// count_compare_capture: timer compare/capture unit driven by an external free-running count
module count_compare_capture #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  count_compare_capture_if.slave bus
);
  localparam logic [WIDTH-1:0] CMP_RST = WIDTH'(1) << (WIDTH - 1);
  logic [WIDTH-1:0] prev_count, shadow;
  logic [SYNC_STAGES-1:0] sync;
  logic cap_q, wrap, rise;
  always_comb begin
    wrap = prev_count == '1 && bus.count == '0;
    rise = sync[SYNC_STAGES-1] & ~cap_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count <= '0;
      shadow <= CMP_RST;
      bus.cmp_val <= CMP_RST;
      bus.cap_val <= '0;
      sync <= '0;
      cap_q <= 1'b0;
      bus.match_pulse <= 1'b0;
      bus.ovf_pulse <= 1'b0;
      bus.cap_pulse <= 1'b0;
      bus.pwm_out <= 1'b0;
      bus.flags <= '0;
      bus.irq <= 1'b0;
    end else begin
      prev_count <= bus.count;
      if (bus.cmp_wr) shadow <= bus.cmp_wdata;
      // active compare reloads only at the wrap, taking the pre-write shadow
      if (wrap) bus.cmp_val <= shadow;
      sync <= {sync[SYNC_STAGES-2:0], bus.cap_in};
      cap_q <= sync[SYNC_STAGES-1];
      if (rise) bus.cap_val <= bus.count;
      bus.match_pulse <= bus.count == bus.cmp_val && prev_count != bus.cmp_val;
      bus.ovf_pulse <= wrap;
      bus.cap_pulse <= rise;
      bus.pwm_out <= bus.count < bus.cmp_val;
      bus.flags <= (bus.flags & ~bus.flag_clr) |
                   {bus.cap_pulse & bus.flags[2], bus.cap_pulse, bus.ovf_pulse, bus.match_pulse};
      bus.irq <= |(bus.flags & bus.irq_en);
    end
  end
endmodule

// File: tb/tb_count_compare_capture.sv
// tb_count_compare_capture: directed and randomized checks against a behavioural model
module tb_count_compare_capture;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  count_compare_capture_if #(.WIDTH(W)) bus();
  count_compare_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0, nerr = 0;
  logic [7:0] cnt;
  logic [7:0] m_prev, m_sh, m_cmp, m_capv, caph;
  logic m_match, m_ovf, m_cap, m_pwm, m_irq;
  logic [3:0] m_flags;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_sh = 8'h80; m_cmp = 8'h80; m_capv = 0; caph = 0;
    m_match = 0; m_ovf = 0; m_cap = 0; m_pwm = 0; m_irq = 0; m_flags = 0;
  endtask

  task automatic model_edge();
    logic [7:0] c;
    logic w, rise;
    c = bus.count;
    w = m_prev == 8'hFF && c == 8'h00;
    rise = caph[S-1] && !caph[S];
    m_irq = |(m_flags & bus.irq_en);
    m_flags = (m_flags & ~bus.flag_clr) | {m_cap && m_flags[2], m_cap, m_ovf, m_match};
    m_match = c == m_cmp && m_prev != m_cmp;
    m_ovf = w;
    m_pwm = c < m_cmp;
    m_cap = rise;
    if (rise) m_capv = c;
    if (w) m_cmp = m_sh;
    if (bus.cmp_wr) m_sh = bus.cmp_wdata;
    m_prev = c;
    caph = {caph[6:0], bus.cap_in};
  endtask

  task automatic check_all();
    chk("cmp_val", bus.cmp_val, m_cmp);
    chk("cap_val", bus.cap_val, m_capv);
    chk("match_pulse", bus.match_pulse, m_match);
    chk("ovf_pulse", bus.ovf_pulse, m_ovf);
    chk("cap_pulse", bus.cap_pulse, m_cap);
    chk("pwm_out", bus.pwm_out, m_pwm);
    chk("flags", bus.flags, m_flags);
    chk("irq", bus.irq, m_irq);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
    cnt = cnt + 8'd1;
    bus.count = cnt;
  endtask

  task automatic run_to(logic [7:0] v);
    while (cnt != v) step();
  endtask

  task automatic period_stats(output int no, output int np, output int nm, output logic [7:0] mat);
    no = 0; np = 0; nm = 0; mat = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      no += int'(bus.ovf_pulse);
      np += int'(bus.pwm_out);
      if (bus.match_pulse) begin nm++; mat = cnt - 8'd1; end
    end
  endtask

  int no, np, nm;
  logic [7:0] mat;

  initial begin
    cnt = 0;
    bus.count = 0; bus.cap_in = 0; bus.cmp_wr = 0; bus.cmp_wdata = 0;
    bus.flag_clr = 0; bus.irq_en = 0;
    model_reset();
    #1 rst = 1;
    #2;
    check_all();
    chk("rst_cmp_val", bus.cmp_val, 8'h80);
    @(posedge clk);
    #1 rst = 0;

    // free-running period with default compare 0x80
    bus.irq_en = 4'b0010;
    step();
    period_stats(no, np, nm, mat);
    chk("ovf_per_period", no, 1);
    chk("pwm_high_80", np, 128);
    chk("match_count_80", nm, 1);
    chk("match_at_80", mat, 8'h80);
    step(); step();
    chk("flag_ovf", bus.flags[1], 1'b1);
    chk("irq_en1", bus.irq, 1'b1);
    bus.irq_en = 4'b0000;
    step(); step();
    chk("irq_masked", bus.irq, 1'b0);

    // shadow write mid-period takes effect only at the wrap
    run_to(8'h10);
    bus.cmp_wr = 1; bus.cmp_wdata = 8'h40;
    step();
    bus.cmp_wr = 0;
    run_to(8'h00);
    chk("cmp_before_wrap", bus.cmp_val, 8'h80);
    step();
    chk("cmp_after_wrap", bus.cmp_val, 8'h40);
    period_stats(no, np, nm, mat);
    chk("pwm_high_40", np, 64);
    chk("match_at_40", mat, 8'h40);

    // write coincident with wrap lands in the shadow only
    run_to(8'h10);
    bus.cmp_wr = 1; bus.cmp_wdata = 8'h60;
    step();
    bus.cmp_wr = 0;
    run_to(8'h00);
    bus.cmp_wr = 1; bus.cmp_wdata = 8'h20;
    step();
    bus.cmp_wr = 0;
    chk("cmp_coincident_old", bus.cmp_val, 8'h60);
    run_to(8'h00);
    step();
    chk("cmp_coincident_next", bus.cmp_val, 8'h20);

    // capture latency and overrun
    bus.flag_clr = 4'hF; step(); bus.flag_clr = 0;
    run_to(8'h20);
    bus.cap_in = 1;
    step(); step(); step();
    chk("cap_pulse_lat", bus.cap_pulse, 1'b1);
    chk("cap_val_22", bus.cap_val, 8'h22);
    bus.cap_in = 0;
    step(); step();
    chk("flag_cap", bus.flags[2], 1'b1);
    chk("flag_ovr_clear", bus.flags[3], 1'b0);
    bus.cap_in = 1;
    repeat (3) step();
    bus.cap_in = 0;
    step(); step();
    chk("flag_overrun", bus.flags[3], 1'b1);

    // set beats clear on the same flag bit
    bus.flag_clr = 4'hF; step(); bus.flag_clr = 0;
    run_to(8'h20);
    step();
    chk("match_at_20", bus.match_pulse, 1'b1);
    bus.flag_clr = 4'b0001;
    step();
    chk("set_wins", bus.flags[0], 1'b1);
    step();
    chk("clr_works", bus.flags[0], 1'b0);
    bus.flag_clr = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.cap_in = ~bus.cap_in;
      bus.cmp_wr = $urandom_range(0, 15) == 0;
      bus.cmp_wdata = 8'($urandom);
      bus.flag_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 31) == 0) bus.irq_en = 4'($urandom);
      step();
    end
    bus.cmp_wr = 0; bus.flag_clr = 0; bus.irq_en = 4'hF;

    // asynchronous reset mid-operation with capture input toggling
    while (cnt != 8'h7F) begin
      bus.cap_in = ~bus.cap_in;
      step();
    end
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("midrst_cmp", bus.cmp_val, 8'h80);
    chk("midrst_flags", bus.flags, 4'h0);
    @(posedge clk); bus.cap_in = ~bus.cap_in;
    @(posedge clk);
    #1 rst = 0;
    cnt = 0; bus.count = 0; bus.cap_in = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", {bus.match_pulse, bus.ovf_pulse, bus.cap_pulse}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
